// File: rtl/softmax_stream_arbiter.sv
// softmax_stream_arbiter
//   Shares one softmax core between two AXI-Stream requesters. Whole input
//   frames are arbitrated onto the core, the granted requester ID is queued in
//   a tag FIFO, and result frames are steered back to their owners in order.
//   Optional macro SOFTMAX_ARB_FIXED_PRIO_EN: s0 always wins a tie (s1 can
//   starve). Default build: round-robin between the requesters.
module softmax_stream_arbiter #(
  parameter int DATA_SIZE = 16,
  parameter int TAG_DEPTH = 4
) (
  input  logic                   axi_clock_i,
  input  logic                   axi_reset_i,
  input  logic                   s0_axis_valid_i,
  input  logic [2*DATA_SIZE-1:0] s0_axis_data_i,
  input  logic                   s0_axis_last_i,
  output logic                   s0_axis_ready_o,
  input  logic                   s1_axis_valid_i,
  input  logic [2*DATA_SIZE-1:0] s1_axis_data_i,
  input  logic                   s1_axis_last_i,
  output logic                   s1_axis_ready_o,
  output logic                   m_axis_valid_o,
  output logic [2*DATA_SIZE-1:0] m_axis_data_o,
  output logic                   m_axis_last_o,
  input  logic                   m_axis_ready_i,
  input  logic                   r_axis_valid_i,
  input  logic [2*DATA_SIZE-1:0] r_axis_data_i,
  input  logic                   r_axis_last_i,
  output logic                   r_axis_ready_o,
  output logic                   o0_axis_valid_o,
  output logic [2*DATA_SIZE-1:0] o0_axis_data_o,
  output logic                   o0_axis_last_o,
  input  logic                   o0_axis_ready_i,
  output logic                   o1_axis_valid_o,
  output logic [2*DATA_SIZE-1:0] o1_axis_data_o,
  output logic                   o1_axis_last_o,
  input  logic                   o1_axis_ready_i,
  output logic                   busy_o
);

  localparam int DW = 2 * DATA_SIZE;
  localparam int PW = $clog2(TAG_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_FWD  = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic            grant_q, grant_d;            // requester owning the current frame
  logic            last_grant_q, last_grant_d;  // owner of the most recent completed frame
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            tag_mem_q [TAG_DEPTH];

  logic            pick;
  logic            push;
  logic            pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic            head;
  logic            sg_valid;
  logic [DW-1:0]   sg_data;
  logic            sg_last;

  assign fifo_full  = (count_q == CW'(TAG_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign head       = tag_mem_q[rd_ptr_q];
  assign busy_o     = (state_q == ST_FWD) || !fifo_empty;

  // Choose which requester would be granted if a new frame starts this cycle.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    pick = 1'b0;
`ifdef SOFTMAX_ARB_FIXED_PRIO_EN
    pick = !s0_axis_valid_i && s1_axis_valid_i;
`else
    if (s0_axis_valid_i && s1_axis_valid_i) begin
      pick = ~last_grant_q;
    end else begin
      pick = s1_axis_valid_i;
    end
`endif
  end

  // Select the granted requester's input stream.
  always_comb begin
    sg_valid = grant_q ? s1_axis_valid_i : s0_axis_valid_i;
    sg_data  = grant_q ? s1_axis_data_i  : s0_axis_data_i;
    sg_last  = grant_q ? s1_axis_last_i  : s0_axis_last_i;
  end

  // Input FSM: grant a frame in IDLE, pass it through to the core in FWD.
  always_comb begin
    // NOTE: combinational logic uses blocking assignments (=); the flops below
    // use non-blocking (<=) so every register samples pre-edge values.
    state_d         = state_q;
    grant_d         = grant_q;
    last_grant_d    = last_grant_q;
    push            = 1'b0;
    m_axis_valid_o  = 1'b0;
    m_axis_data_o   = '0;
    m_axis_last_o   = 1'b0;
    s0_axis_ready_o = 1'b0;
    s1_axis_ready_o = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_full && (s0_axis_valid_i || s1_axis_valid_i)) begin
          state_d = ST_FWD;
          grant_d = pick;
          push    = 1'b1;
        end
      end
      ST_FWD: begin
        m_axis_valid_o  = sg_valid;
        m_axis_data_o   = sg_data;
        m_axis_last_o   = sg_last;
        s0_axis_ready_o = !grant_q && m_axis_ready_i;
        s1_axis_ready_o =  grant_q && m_axis_ready_i;
        if (sg_valid && m_axis_ready_i && sg_last) begin
          state_d      = ST_IDLE;
          last_grant_d = grant_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Return path: steer core results to the requester at the tag FIFO head.
  always_comb begin
    r_axis_ready_o  = 1'b0;
    o0_axis_valid_o = 1'b0;
    o0_axis_last_o  = 1'b0;
    o0_axis_data_o  = '0;
    o1_axis_valid_o = 1'b0;
    o1_axis_last_o  = 1'b0;
    o1_axis_data_o  = '0;
    if (!fifo_empty) begin
      r_axis_ready_o  = head ? o1_axis_ready_i : o0_axis_ready_i;
      o0_axis_data_o  = r_axis_data_i;
      o1_axis_data_o  = r_axis_data_i;
      o0_axis_valid_o = !head && r_axis_valid_i;
      o0_axis_last_o  = !head && r_axis_last_i;
      o1_axis_valid_o =  head && r_axis_valid_i;
      o1_axis_last_o  =  head && r_axis_last_i;
    end
    pop = !fifo_empty && r_axis_valid_i && r_axis_ready_o && r_axis_last_i;
  end

  // Tag FIFO pointer and occupancy update; push and pop may coincide.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  // Control registers with synchronous active-high reset.
  always_ff @(posedge axi_clock_i) begin
    if (axi_reset_i) begin
      state_q      <= ST_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  // Tag storage written on grant.
  always_ff @(posedge axi_clock_i) begin
    // NOTE: the tag array is not reset; an entry is only read after it has been
    // written, because count_q gates every read.
    if (push) begin
      tag_mem_q[wr_ptr_q] <= grant_d;
    end
  end

endmodule

// File: tb/tb_softmax_stream_arbiter.sv
// Directed self-checking bench for softmax_stream_arbiter (default build).
module tb_softmax_stream_arbiter;

  localparam bit T = 1'b1;
  localparam bit F = 1'b0;

  logic        clk = 1'b0;
  logic        rst;
  logic        s0_v, s0_l, s0_rdy;
  logic [31:0] s0_d;
  logic        s1_v, s1_l, s1_rdy;
  logic [31:0] s1_d;
  logic        m_v, m_l, m_rdy;
  logic [31:0] m_d;
  logic        r_v, r_l, r_rdy;
  logic [31:0] r_d;
  logic        o0_v, o0_l, o0_rdy;
  logic [31:0] o0_d;
  logic        o1_v, o1_l, o1_rdy;
  logic [31:0] o1_d;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  softmax_stream_arbiter #(.DATA_SIZE(16), .TAG_DEPTH(4)) dut (
    .axi_clock_i    (clk),
    .axi_reset_i    (rst),
    .s0_axis_valid_i(s0_v),
    .s0_axis_data_i (s0_d),
    .s0_axis_last_i (s0_l),
    .s0_axis_ready_o(s0_rdy),
    .s1_axis_valid_i(s1_v),
    .s1_axis_data_i (s1_d),
    .s1_axis_last_i (s1_l),
    .s1_axis_ready_o(s1_rdy),
    .m_axis_valid_o (m_v),
    .m_axis_data_o  (m_d),
    .m_axis_last_o  (m_l),
    .m_axis_ready_i (m_rdy),
    .r_axis_valid_i (r_v),
    .r_axis_data_i  (r_d),
    .r_axis_last_i  (r_l),
    .r_axis_ready_o (r_rdy),
    .o0_axis_valid_o(o0_v),
    .o0_axis_data_o (o0_d),
    .o0_axis_last_o (o0_l),
    .o0_axis_ready_i(o0_rdy),
    .o1_axis_valid_o(o1_v),
    .o1_axis_data_o (o1_d),
    .o1_axis_last_o (o1_l),
    .o1_axis_ready_i(o1_rdy),
    .busy_o         (busy)
  );

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%b expected=%b", name, act, exp);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    s0_v = 1'b0; s0_l = 1'b0; s0_d = '0;
    s1_v = 1'b0; s1_l = 1'b0; s1_d = '0;
    m_rdy = 1'b0;
    r_v = 1'b0; r_l = 1'b0; r_d = '0;
    o0_rdy = 1'b0; o1_rdy = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    clear_inputs();
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    check1({tag, "_s0_ready"}, s0_rdy, 1'b0);
    check1({tag, "_s1_ready"}, s1_rdy, 1'b0);
    check1({tag, "_m_valid"},  m_v,    1'b0);
    check1({tag, "_m_last"},   m_l,    1'b0);
    check32({tag, "_m_data"},  m_d,    32'h0);
    check1({tag, "_r_ready"},  r_rdy,  1'b0);
    check1({tag, "_o0_valid"}, o0_v,   1'b0);
    check1({tag, "_o0_last"},  o0_l,   1'b0);
    check32({tag, "_o0_data"}, o0_d,   32'h0);
    check1({tag, "_o1_valid"}, o1_v,   1'b0);
    check1({tag, "_o1_last"},  o1_l,   1'b0);
    check32({tag, "_o1_data"}, o1_d,   32'h0);
    check1({tag, "_busy"},     busy,   1'b0);
  endtask

  typedef struct {
    bit          s0_v;
    bit          s0_l;
    logic [31:0] s0_d;
    bit          s1_v;
    bit          s1_l;
    logic [31:0] s1_d;
    bit          m_rdy;
    bit          e_s0_rdy;
    bit          e_s1_rdy;
    bit          e_m_v;
    bit          e_m_l;
    logic [31:0] e_m_d;
    bit          e_busy;
  } vec_t;

  localparam logic [31:0] A0 = 32'hA000_0000, A1 = 32'hA000_0001, A2 = 32'hA000_0002;
  localparam logic [31:0] B0 = 32'hB000_0000, B1 = 32'hB000_0001, B2 = 32'hB000_0002;
  localparam logic [31:0] C0 = 32'hC000_0000;
  localparam logic [31:0] Z  = 32'h0;

  logic [31:0] f2 [5] = '{32'hBFE147AE, 32'hC01820C4, 32'h40558106, 32'hC04B74BC, 32'hBF59DB22};
  vec_t        vecs [13];

  initial begin
    logic [31:0] cap_d [$];
    logic        cap_l [$];
    int          sent, got, o1_seen, acc;

    rst = 1'b1;
    clear_inputs();

    // ---- 1: reset with every input valid/ready high
    s0_v = 1'b1; s0_l = 1'b1; s0_d = 32'h1111_1111;
    s1_v = 1'b1; s1_l = 1'b1; s1_d = 32'h2222_2222;
    m_rdy = 1'b1; r_v = 1'b1; r_l = 1'b1; r_d = 32'h3333_3333;
    o0_rdy = 1'b1; o1_rdy = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #2;
      check_quiet("t1_reset");
    end

    // ---- 2: s0 five-beat frame with core loopback
    reset_dut();
    sent = 0; o1_seen = 0;
    for (int c = 0; c < 40 && sent < 5; c++) begin
      s0_v = 1'b1; s0_d = f2[sent]; s0_l = (sent == 4); m_rdy = 1'b1;
      #1;
      if (o1_v) o1_seen++;
      if (m_v && m_rdy) begin
        cap_d.push_back(m_d);
        cap_l.push_back(m_l);
      end
      if (s0_rdy) sent++;
      next_cycle();
    end
    s0_v = 1'b0; s0_l = 1'b0; m_rdy = 1'b0;
    #1;
    check32("t2_beats_sent", 32'(sent), 32'd5);
    check32("t2_beats_on_m", 32'(cap_d.size()), 32'd5);
    check1("t2_busy_in_flight", busy, 1'b1);
    for (int i = 0; i < 5 && i < cap_d.size(); i++) begin
      check32("t2_m_data", cap_d[i], f2[i]);
      check1("t2_m_last", cap_l[i], (i == 4));
    end
    got = 0;
    for (int c = 0; c < 40 && got < 5 && cap_d.size() == 5; c++) begin
      r_v = 1'b1; r_d = cap_d[got]; r_l = cap_l[got]; o0_rdy = 1'b1; o1_rdy = 1'b1;
      #1;
      if (o1_v) o1_seen++;
      if (o0_v && r_rdy) begin
        check32("t2_o0_data", o0_d, f2[got]);
        check1("t2_o0_last", o0_l, (got == 4));
        got++;
      end
      next_cycle();
    end
    r_v = 1'b0; r_l = 1'b0;
    #1;
    check32("t2_beats_returned", 32'(got), 32'd5);
    check32("t2_o1_valid_seen", 32'(o1_seen), 32'd0);
    check1("t2_busy_after_pop", busy, 1'b0);

    // ---- 3/4: simultaneous requests, round robin, ready pattern 1,0,1,0
    vecs[0]  = '{T, F, A0, T, F, B0, T,  F, F, F, F, Z,  F};
    vecs[1]  = '{T, F, A0, T, F, B0, T,  T, F, T, F, A0, T};
    vecs[2]  = '{T, F, A1, T, F, B0, F,  F, F, T, F, A1, T};
    vecs[3]  = '{T, F, A1, T, F, B0, T,  T, F, T, F, A1, T};
    vecs[4]  = '{T, T, A2, T, F, B0, F,  F, F, T, T, A2, T};
    vecs[5]  = '{T, T, A2, T, F, B0, T,  T, F, T, T, A2, T};
    vecs[6]  = '{T, T, C0, T, F, B0, T,  F, F, F, F, Z,  T};
    vecs[7]  = '{T, T, C0, T, F, B0, T,  F, T, T, F, B0, T};
    vecs[8]  = '{T, T, C0, T, F, B1, T,  F, T, T, F, B1, T};
    vecs[9]  = '{T, T, C0, T, T, B2, T,  F, T, T, T, B2, T};
    vecs[10] = '{T, T, C0, F, F, Z,  T,  F, F, F, F, Z,  T};
    vecs[11] = '{T, T, C0, F, F, Z,  T,  T, F, T, T, C0, T};
    vecs[12] = '{F, F, Z,  F, F, Z,  T,  F, F, F, F, Z,  T};
    reset_dut();
    for (int i = 0; i < 13; i++) begin
      s0_v = vecs[i].s0_v; s0_l = vecs[i].s0_l; s0_d = vecs[i].s0_d;
      s1_v = vecs[i].s1_v; s1_l = vecs[i].s1_l; s1_d = vecs[i].s1_d;
      m_rdy = vecs[i].m_rdy;
      #1;
      check1($sformatf("t3_v%0d_s0_ready", i), s0_rdy, vecs[i].e_s0_rdy);
      check1($sformatf("t3_v%0d_s1_ready", i), s1_rdy, vecs[i].e_s1_rdy);
      check1($sformatf("t3_v%0d_m_valid", i),  m_v,    vecs[i].e_m_v);
      check1($sformatf("t3_v%0d_m_last", i),   m_l,    vecs[i].e_m_l);
      check32($sformatf("t3_v%0d_m_data", i),  m_d,    vecs[i].e_m_d);
      check1($sformatf("t3_v%0d_busy", i),     busy,   vecs[i].e_busy);
      next_cycle();
    end
    clear_inputs();
    // Results return in issue order: s0 (2 beats), s1 (1 beat), s0 (1 beat).
    o0_rdy = 1'b1; o1_rdy = 1'b1;
    r_v = 1'b1; r_d = 32'hD000_0000; r_l = 1'b0;
    #1;
    check1("t3_ret0_o0_valid", o0_v, 1'b1);
    check1("t3_ret0_o1_valid", o1_v, 1'b0);
    check1("t3_ret0_r_ready", r_rdy, 1'b1);
    check32("t3_ret0_o0_data", o0_d, 32'hD000_0000);
    check1("t3_ret0_o0_last", o0_l, 1'b0);
    next_cycle();
    r_d = 32'hD000_0001; r_l = 1'b1;
    #1;
    check1("t3_ret1_o0_valid", o0_v, 1'b1);
    check1("t3_ret1_o0_last", o0_l, 1'b1);
    next_cycle();
    r_d = 32'hD000_0002; r_l = 1'b1;
    #1;
    check1("t3_ret2_o1_valid", o1_v, 1'b1);
    check1("t3_ret2_o0_valid", o0_v, 1'b0);
    check32("t3_ret2_o1_data", o1_d, 32'hD000_0002);
    check1("t3_ret2_o1_last", o1_l, 1'b1);
    next_cycle();
    r_d = 32'hD000_0003; o0_rdy = 1'b0;
    #1;
    check1("t3_ret3_o0_valid", o0_v, 1'b1);
    check1("t3_ret3_r_ready_stall", r_rdy, 1'b0);
    next_cycle();
    o0_rdy = 1'b1;
    #1;
    check1("t3_ret3_r_ready", r_rdy, 1'b1);
    check1("t3_ret3_busy", busy, 1'b1);
    next_cycle();
    #1;
    check1("t3_stray_r_ready", r_rdy, 1'b0);
    check1("t3_stray_o0_valid", o0_v, 1'b0);
    check1("t3_stray_o1_valid", o1_v, 1'b0);
    check1("t3_idle_busy", busy, 1'b0);

    // ---- 5: tag FIFO fills after four frames, one release admits the fifth
    reset_dut();
    m_rdy = 1'b1;
    acc = 0;
    for (int c = 0; c < 40 && acc < 4; c++) begin
      s0_v = 1'b1; s0_l = 1'b1; s0_d = 32'h100 + 32'(acc);
      #1;
      if (s0_rdy && m_v) acc++;
      next_cycle();
    end
    check32("t5_frames_accepted", 32'(acc), 32'd4);
    s0_d = 32'h200;
    for (int c = 0; c < 3; c++) begin
      #1;
      check1("t5_full_s0_ready", s0_rdy, 1'b0);
      check1("t5_full_m_valid", m_v, 1'b0);
      next_cycle();
    end
    r_v = 1'b1; r_l = 1'b1; r_d = 32'h5555_0000; o0_rdy = 1'b1;
    #1;
    check1("t5_release_r_ready", r_rdy, 1'b1);
    check1("t5_release_o0_valid", o0_v, 1'b1);
    check1("t5_release_s0_ready", s0_rdy, 1'b0);
    next_cycle();
    r_v = 1'b0; r_l = 1'b0;
    #1;
    check1("t5_grant_cycle_s0_ready", s0_rdy, 1'b0);
    check1("t5_grant_cycle_m_valid", m_v, 1'b0);
    next_cycle();
    #1;
    check1("t5_fwd_s0_ready", s0_rdy, 1'b1);
    check1("t5_fwd_m_valid", m_v, 1'b1);
    check32("t5_fwd_m_data", m_d, 32'h200);
    next_cycle();
    clear_inputs();

    // ---- 6: reset mid-frame, then an s1 frame serviced normally
    reset_dut();
    m_rdy = 1'b1;
    s0_v = 1'b1; s0_l = 1'b0; s0_d = f2[0];
    next_cycle();
    #1;
    check32("t6_beat0_m_data", m_d, f2[0]);
    next_cycle();
    s0_d = f2[1];
    next_cycle();
    s0_d = f2[2];
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    s0_v = 1'b0;
    s1_v = 1'b1; s1_l = 1'b0; s1_d = 32'hE000_0000;
    r_v = 1'b1; r_l = 1'b1; r_d = 32'hEE00_0000; o0_rdy = 1'b1; o1_rdy = 1'b1;
    #1;
    check_quiet("t6_after_reset");
    next_cycle();
    r_v = 1'b0;
    #1;
    check1("t6_fwd_s1_ready", s1_rdy, 1'b1);
    check1("t6_fwd_s0_ready", s0_rdy, 1'b0);
    check32("t6_fwd_m_data0", m_d, 32'hE000_0000);
    next_cycle();
    s1_d = 32'hE000_0001; s1_l = 1'b1;
    #1;
    check32("t6_fwd_m_data1", m_d, 32'hE000_0001);
    check1("t6_fwd_m_last", m_l, 1'b1);
    next_cycle();
    s1_v = 1'b0; s1_l = 1'b0;
    r_v = 1'b1; r_l = 1'b1; r_d = 32'hEE00_0001;
    #1;
    check1("t6_ret_o1_valid", o1_v, 1'b1);
    check1("t6_ret_o0_valid", o0_v, 1'b0);
    check32("t6_ret_o1_data", o1_d, 32'hEE00_0001);
    check1("t6_ret_r_ready", r_rdy, 1'b1);
    next_cycle();
    r_v = 1'b0;
    #1;
    check1("t6_busy_done", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
